fetch_controller: RTL and testbench

- Sequences the byte-addressed, 32-byte instruction memory (big-endian, combinational read of 4 bytes at `mem_addr`). It owns the PC, issues one word fetch per cycle into a 2-entry prefetch buffer, and presents instructions to decode with a valid/ready handshake.
- Applies branch/jump redirects, flushing stale prefetches.
- Sits between instruction memory and the decode stage of the MIPS datapath.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 99 +++++++++
 rtl/fetch_controller.sv | 102 ++++++++++
 tb/tb_fetch_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch path: fetch FSM state encoding,
// instruction width, PC increment and the beq target calculation (also used
// by the branch unit, so it lives here rather than in the controller).
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  // beq target: word-aligned branch address + 4 + (sign-extended imm16 << 2).
  // Evaluated at 32 bits, then masked to addr_w bits so callers can truncate.
  function automatic logic [31:0] branch_target(input logic [31:0]  pc,
                                                input logic [15:0]  imm16,
                                                input int unsigned  addr_w);
    logic [31:0] base;
    logic [31:0] offs;
    logic [31:0] mask;
    base = {pc[31:2], 2'b00};
    offs = {{14{imm16[15]}}, imm16, 2'b00};
    mask = (addr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << addr_w) - 32'd1);
    return (base + 32'(PC_STEP) + offs) & mask;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry prefetch buffer of {pc, instr} pairs. Head entry is presented
// combinationally. A push into a full buffer is accepted only when a pop
// frees a slot in the same cycle. flush_i empties the buffer and overrides
// push and pop.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i, pop_i       write / remove-head requests
//   flush_i             drop all entries, reset pointers
//   push_pc_i/instr_i   entry being written
//   head_pc_o/instr_o   oldest entry (stale value when empty)
//   count_o             number of valid entries
//   full_o, empty_o     occupancy flags
// ---------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [ADDR_W-1:0]       push_pc_i,
  input  logic [INSTR_W-1:0]      push_instr_i,
  output logic [ADDR_W-1:0]       head_pc_o,
  output logic [INSTR_W-1:0]      head_instr_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  pc_q    [DEPTH];
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               do_push, do_pop;

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign head_pc_o    = pc_q[rd_ptr_q];
  assign head_instr_o = instr_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  // NOTE: the storage array is reset too (it is tiny) so the head outputs
  // read zero out of reset instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments for all clocked state, so every
      // register samples pre-edge values regardless of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) begin
        pc_q[wr_ptr_q]    <= push_pc_i;
        instr_q[wr_ptr_q] <= push_instr_i;
      end
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
// Owns the PC, fetches one word per cycle from a combinational instruction
// memory into a prefetch buffer and hands instructions to decode with a
// valid/ready handshake. Branch/jump redirects flush the buffer, load the
// new PC and insert one bubble cycle before fetching resumes.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem_addr / mem_instr        instruction memory address / returned word
//   instr_valid/ready/out       decode handshake and head instruction
//   pc_out                      address of the head instruction
//   branch_taken, branch_pc,
//   branch_offset               taken beq redirect and its operands
//   jump, jump_index            j redirect and its target field
// ---------------------------------------------------------------------------
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 5,
  parameter int unsigned          DEPTH    = 2,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [INSTR_W-1:0]  mem_instr,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr_out,
  output logic [ADDR_W-1:0]   pc_out,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_pc,
  input  logic [15:0]         branch_offset,
  input  logic                jump,
  input  logic [25:0]         jump_index
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                push, pop, redirect;
  logic [ADDR_W-1:0]   jump_tgt, br_tgt, redirect_tgt;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                fifo_full, fifo_empty;

  assign mem_addr    = pc_q;
  assign instr_valid = (fifo_count != '0);

  // Redirects are not accepted in BOOT; outside BOOT they beat push and pop.
  assign redirect     = (jump || branch_taken) && (state_q != BOOT);
  assign jump_tgt     = ADDR_W'({jump_index, 2'b00});
  assign br_tgt       = ADDR_W'(branch_target(32'(branch_pc), branch_offset, ADDR_W));
  assign redirect_tgt = jump ? jump_tgt : br_tgt;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = !fifo_empty && instr_ready && !redirect;
    case (state_q)
      BOOT:     state_d = FETCH;
      FETCH:    push    = !redirect && (!fifo_full || pop);
      REDIRECT: state_d = FETCH;
      default:  state_d = BOOT;
    endcase
    if (redirect) begin
      pc_d    = redirect_tgt;
      state_d = REDIRECT;
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (redirect),
    .push_pc_i    (pc_q),
    .push_instr_i (mem_instr),
    .head_pc_o    (pc_out),
    .head_instr_o (instr_out),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
// Directed bench for fetch_controller with a 32-byte big-endian instruction
// memory. Outputs are sampled on the falling edge; inputs change there too.
// ---------------------------------------------------------------------------
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic [4:0]  mem_addr;
  logic [31:0] mem_instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [4:0]  pc_out;
  logic        branch_taken;
  logic [4:0]  branch_pc;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;

  int checks;
  int failures;

  logic [7:0] imem [0:31];

  fetch_controller #(
    .ADDR_W   (5),
    .DEPTH    (2),
    .RESET_PC (5'd0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_instr     (mem_instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .branch_taken  (branch_taken),
    .branch_pc     (branch_pc),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Word stored at each aligned address.
  function automatic logic [31:0] exp_word(input logic [4:0] a);
    if (a == 5'd0) return 32'h0000_0000;
    if (a == 5'd4) return 32'h1109_0001;
    return 32'hA500_0000 + 32'(a);
  endfunction

  initial begin
    for (int w = 0; w < 8; w++) begin
      logic [31:0] v;
      v = exp_word(5'(w * 4));
      imem[w*4]     = v[31:24];
      imem[w*4 + 1] = v[23:16];
      imem[w*4 + 2] = v[15:8];
      imem[w*4 + 3] = v[7:0];
    end
  end

  assign mem_instr = {imem[mem_addr], imem[mem_addr + 5'd1],
                      imem[mem_addr + 5'd2], imem[mem_addr + 5'd3]};

  task automatic apply_reset(input logic ready);
    rst_n         = 1'b0;
    instr_ready   = ready;
    branch_taken  = 1'b0;
    branch_pc     = '0;
    branch_offset = '0;
    jump          = 1'b0;
    jump_index    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for instr_valid on a falling edge; compares nothing.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    apply_reset(1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({instr_valid, mem_addr, pc_out, instr_out} !== {1'b0, 5'd0, 5'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_state: valid=%0b mem_addr=%0d pc_out=%0d instr=%h expected 0/0/0/0",
               instr_valid, mem_addr, pc_out, instr_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL boot_cycle_valid: got %0b expected 0", instr_valid);
    end
    @(negedge clk);
    checks++;
    if ({instr_valid, pc_out, instr_out} !== {1'b1, 5'd0, 32'h0}) begin
      failures++;
      $display("FAIL first_valid: valid=%0b pc_out=%0d instr=%h expected 1/0/00000000",
               instr_valid, pc_out, instr_out);
    end
  endtask

  task automatic test_stream;
    logic [4:0] e;
    apply_reset(1'b1);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e = 5'(i * 4);
      checks++;
      if ({instr_valid, pc_out, instr_out} !== {1'b1, e, exp_word(e)}) begin
        failures++;
        $display("FAIL stream[%0d]: valid=%0b pc_out=%0d instr=%h expected 1/%0d/%h",
                 i, instr_valid, pc_out, instr_out, e, exp_word(e));
      end
    end
  endtask

  task automatic test_stall;
    logic [4:0] e;
    apply_reset(1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      e = (i == 0) ? 5'd4 : 5'd8;
      checks++;
      if ({instr_valid, pc_out, instr_out, mem_addr} !== {1'b1, 5'd0, 32'h0, e}) begin
        failures++;
        $display("FAIL stall[%0d]: valid=%0b pc_out=%0d instr=%h mem_addr=%0d expected 1/0/00000000/%0d",
                 i, instr_valid, pc_out, instr_out, mem_addr, e);
      end
      @(negedge clk);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = 5'(k * 4);
      checks++;
      if ({instr_valid, pc_out, instr_out} !== {1'b1, e, exp_word(e)}) begin
        failures++;
        $display("FAIL stall_release[%0d]: valid=%0b pc_out=%0d instr=%h expected 1/%0d/%h",
                 k, instr_valid, pc_out, instr_out, e, exp_word(e));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch;
    bit ok;
    apply_reset(1'b1);
    repeat (2) @(negedge clk);
    // Forward branch: 4 + 4 + 4 = 12.
    branch_taken = 1'b1; branch_pc = 5'd4; branch_offset = 16'h0001;
    @(negedge clk);
    branch_taken = 1'b0;
    checks++;
    if ({instr_valid, mem_addr} !== {1'b0, 5'd12}) begin
      failures++;
      $display("FAIL branch_fwd_flush: valid=%0b mem_addr=%0d expected 0/12", instr_valid, mem_addr);
    end
    wait_valid(ok);
    checks++;
    if ({ok, pc_out, instr_out} !== {1'b1, 5'd12, exp_word(5'd12)}) begin
      failures++;
      $display("FAIL branch_fwd_target: seen=%0b pc_out=%0d instr=%h expected 1/12/%h",
               ok, pc_out, instr_out, exp_word(5'd12));
    end
    // Backward branch: 4 + 4 - 8 = 0.
    branch_taken = 1'b1; branch_pc = 5'd4; branch_offset = 16'hFFFE;
    @(negedge clk);
    branch_taken = 1'b0;
    checks++;
    if ({instr_valid, mem_addr} !== {1'b0, 5'd0}) begin
      failures++;
      $display("FAIL branch_back_flush: valid=%0b mem_addr=%0d expected 0/0", instr_valid, mem_addr);
    end
    wait_valid(ok);
    checks++;
    if ({ok, pc_out, instr_out} !== {1'b1, 5'd0, 32'h0}) begin
      failures++;
      $display("FAIL branch_back_target: seen=%0b pc_out=%0d instr=%h expected 1/0/00000000",
               ok, pc_out, instr_out);
    end
  endtask

  task automatic test_jump;
    bit ok;
    apply_reset(1'b1);
    repeat (2) @(negedge clk);
    jump = 1'b1; jump_index = 26'h000_0005;
    @(negedge clk);
    jump = 1'b0;
    checks++;
    if ({instr_valid, mem_addr} !== {1'b0, 5'd20}) begin
      failures++;
      $display("FAIL jump_flush: valid=%0b mem_addr=%0d expected 0/20", instr_valid, mem_addr);
    end
    wait_valid(ok);
    checks++;
    if ({ok, pc_out, instr_out} !== {1'b1, 5'd20, exp_word(5'd20)}) begin
      failures++;
      $display("FAIL jump_target: seen=%0b pc_out=%0d instr=%h expected 1/20/%h",
               ok, pc_out, instr_out, exp_word(5'd20));
    end
    // Jump and branch together: branch would go to 12, jump to 20.
    jump = 1'b1; jump_index = 26'h000_0005;
    branch_taken = 1'b1; branch_pc = 5'd4; branch_offset = 16'h0001;
    @(negedge clk);
    jump = 1'b0; branch_taken = 1'b0;
    checks++;
    if ({instr_valid, mem_addr} !== {1'b0, 5'd20}) begin
      failures++;
      $display("FAIL jump_wins_flush: valid=%0b mem_addr=%0d expected 0/20", instr_valid, mem_addr);
    end
    wait_valid(ok);
    checks++;
    if ({ok, pc_out} !== {1'b1, 5'd20}) begin
      failures++;
      $display("FAIL jump_wins_target: seen=%0b pc_out=%0d expected 1/20", ok, pc_out);
    end
  endtask

  task automatic test_redirect_pop_full;
    bit ok;
    apply_reset(1'b0);
    repeat (3) @(negedge clk);
    // Buffer holds 0 and 4; pop and redirect requested together.
    instr_ready = 1'b1;
    jump = 1'b1; jump_index = 26'h000_0005;
    @(negedge clk);
    jump = 1'b0;
    checks++;
    if ({instr_valid, mem_addr} !== {1'b0, 5'd20}) begin
      failures++;
      $display("FAIL pop_redirect_flush: valid=%0b mem_addr=%0d expected 0/20", instr_valid, mem_addr);
    end
    wait_valid(ok);
    checks++;
    if ({ok, pc_out, instr_out} !== {1'b1, 5'd20, exp_word(5'd20)}) begin
      failures++;
      $display("FAIL pop_redirect_target: seen=%0b pc_out=%0d instr=%h expected 1/20/%h",
               ok, pc_out, instr_out, exp_word(5'd20));
    end
    @(negedge clk);
    checks++;
    if ({instr_valid, pc_out} !== {1'b1, 5'd24}) begin
      failures++;
      $display("FAIL pop_redirect_next: valid=%0b pc_out=%0d expected 1/24", instr_valid, pc_out);
    end
    // First redirect to 28, then a second one to 8 during the bubble.
    jump = 1'b1; jump_index = 26'h000_0007;
    @(negedge clk);
    checks++;
    if ({instr_valid, mem_addr} !== {1'b0, 5'd28}) begin
      failures++;
      $display("FAIL double_first: valid=%0b mem_addr=%0d expected 0/28", instr_valid, mem_addr);
    end
    jump_index = 26'h000_0002;
    @(negedge clk);
    jump = 1'b0;
    checks++;
    if ({instr_valid, mem_addr} !== {1'b0, 5'd8}) begin
      failures++;
      $display("FAIL double_second: valid=%0b mem_addr=%0d expected 0/8", instr_valid, mem_addr);
    end
    wait_valid(ok);
    checks++;
    if ({ok, pc_out, instr_out} !== {1'b1, 5'd8, exp_word(5'd8)}) begin
      failures++;
      $display("FAIL double_target: seen=%0b pc_out=%0d instr=%h expected 1/8/%h",
               ok, pc_out, instr_out, exp_word(5'd8));
    end
    @(negedge clk);
    checks++;
    if ({instr_valid, pc_out} !== {1'b1, 5'd12}) begin
      failures++;
      $display("FAIL double_next: valid=%0b pc_out=%0d expected 1/12", instr_valid, pc_out);
    end
  endtask

  task automatic test_async_reset;
    apply_reset(1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if ({instr_valid, mem_addr} !== {1'b1, 5'd8}) begin
      failures++;
      $display("FAIL pre_async_full: valid=%0b mem_addr=%0d expected 1/8", instr_valid, mem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({instr_valid, mem_addr} !== {1'b0, 5'd0}) begin
      failures++;
      $display("FAIL async_reset: valid=%0b mem_addr=%0d expected 0/0", instr_valid, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_jump();
    test_redirect_pop_full();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
